uart_tx_frame: RTL and testbench

Parametrised UART transmitter that supersedes the fixed 8N1 transmitter. It supports configurable data width, parity and stop bits, and double-buffered or FIFO-buffered loading with overrun detection. It sits between the CPU's console/teleprinter output register and the serial pin, and transmits queued characters back-to-back with no idle gap.

---
 rtl/uart_tx_frame.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter (data width, parity, stop bits) with zero-gap back-to-back frames.
// Define UART_TX_FIFO_EN for a FifoDepth-entry FIFO; otherwise a single holding register is used.
module uart_tx_frame #(
  parameter int unsigned ClockRate = 50_000_000,
  parameter int unsigned Baud      = 115_200,
  parameter int unsigned DataBits  = 8,
  parameter int unsigned Parity    = 0,
  parameter int unsigned StopBits  = 1,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                tx_load,
  input  logic [DataBits-1:0] tx_data,
  output logic                tx_ready,
  output logic                tx_busy,
  output logic                tx_overrun,
  output logic                tx
);

  localparam int unsigned Divider = ClockRate / Baud;
  localparam int unsigned BaudW   = (Divider > 1) ? $clog2(Divider) : 1;
  localparam int unsigned CntW    = 4;
  localparam logic [BaudW-1:0] BaudReload = BaudW'(Divider - 1);
  localparam logic [CntW-1:0]  LastData   = CntW'(DataBits - 1);
  localparam logic [CntW-1:0]  LastStop   = CntW'(StopBits - 1);

  if (Divider < 2) begin : g_chk_divider
    $error("uart_tx_frame: ClockRate/Baud must be at least 2");
  end
  if (DataBits < 5 || DataBits > 9) begin : g_chk_databits
    $error("uart_tx_frame: DataBits must be 5..9");
  end
  if (Parity > 2) begin : g_chk_parity
    $error("uart_tx_frame: Parity must be 0, 1 or 2");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_chk_stopbits
    $error("uart_tx_frame: StopBits must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BaudW-1:0]    baud_q, baud_d;
  logic [CntW-1:0]     bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;

  logic                tick;
  logic                pop;
  logic                push;
  logic                buf_empty;
  logic                buf_full_d;
  logic                buf_empty_d;
  logic [DataBits-1:0] buf_rd_data;

  // Acceptance uses the registered ready, so a full buffer rejects even when it pops this cycle.
  assign push = tx_load & ready_q;
  assign tick = (baud_q == '0);

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AddrW = $clog2(FifoDepth);

  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_frame: FifoDepth must be a power of two >= 2");
  end

  logic [AddrW:0]      wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]      rd_ptr_q, rd_ptr_d;
  logic [DataBits-1:0] fifo_mem_q [FifoDepth];

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{AddrW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AddrW{1'b0}}, pop};
    buf_empty   = (wr_ptr_q == rd_ptr_q);
    buf_rd_data = fifo_mem_q[rd_ptr_q[AddrW-1:0]];
    buf_empty_d = (wr_ptr_d == rd_ptr_d);
    buf_full_d  = ((wr_ptr_d ^ rd_ptr_d) == {1'b1, {AddrW{1'b0}}});
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[AddrW-1:0]] <= tx_data;
  end
`else
  logic                hold_valid_q, hold_valid_d;
  logic [DataBits-1:0] hold_data_q, hold_data_d;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (pop) hold_valid_d = 1'b0;
    if (push) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data;
    end
    buf_empty   = !hold_valid_q;
    buf_rd_data = hold_data_q;
    buf_empty_d = !hold_valid_d;
    buf_full_d  = hold_valid_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    pop      = 1'b0;

    if (state_q != S_IDLE) baud_d = tick ? BaudReload : baud_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!buf_empty) pop = 1'b1;
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == LastData) begin
            if (Parity != 0) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              bit_d   = '0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q != LastStop) begin
            bit_d = bit_q + 1'b1;
          end else if (!buf_empty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A pop from IDLE or the last stop bit starts the next frame on the very next clock.
    if (pop) begin
      state_d  = S_START;
      baud_d   = BaudReload;
      shift_d  = buf_rd_data;
      tx_d     = 1'b0;
      parity_d = (Parity == 1) ? ~^buf_rd_data : ^buf_rd_data;
    end
  end

  always_comb begin
    ready_d   = !buf_full_d;
    busy_d    = (state_d != S_IDLE) || !buf_empty_d;
    overrun_d = overrun_q | (tx_load & !ready_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx         = tx_q;
  assign tx_ready   = ready_q;
  assign tx_busy    = busy_q;
  assign tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: 8N1 /5, 7E2 /4 and 7O2 /4 instances with per-line frame monitors.
module tb_uart_tx_frame;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic       ld8 = 1'b0;
  logic [7:0] d8  = '0;
  logic       rdy8, busy8, ovr8, tx8;
  logic       lde = 1'b0;
  logic [6:0] de  = '0;
  logic       rdye, busye, ovre, txe;
  logic       ldo = 1'b0;
  logic [6:0] dod = '0;
  logic       rdyo, busyo, ovro, txo;

  uart_tx_frame #(.ClockRate(50), .Baud(10), .DataBits(8), .Parity(0), .StopBits(1), .FifoDepth(4)) u8 (
    .clk(clk), .nrst(nrst), .tx_load(ld8), .tx_data(d8),
    .tx_ready(rdy8), .tx_busy(busy8), .tx_overrun(ovr8), .tx(tx8));

  uart_tx_frame #(.ClockRate(40), .Baud(10), .DataBits(7), .Parity(2), .StopBits(2), .FifoDepth(4)) ue (
    .clk(clk), .nrst(nrst), .tx_load(lde), .tx_data(de),
    .tx_ready(rdye), .tx_busy(busye), .tx_overrun(ovre), .tx(txe));

  uart_tx_frame #(.ClockRate(40), .Baud(10), .DataBits(7), .Parity(1), .StopBits(2), .FifoDepth(4)) uo (
    .clk(clk), .nrst(nrst), .tx_load(ldo), .tx_data(dod),
    .tx_ready(rdyo), .tx_busy(busyo), .tx_overrun(ovro), .tx(txo));

  typedef struct {
    logic [15:0] bits;
    int          nb;
  } frame_t;

  frame_t q0[$];
  frame_t q1[$];
  frame_t q2[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic frame_t make_frame(input logic [8:0] d, input int dbits, input int par, input int stops);
    frame_t f;
    int     n;
    logic   p;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    n         = 1;
    p         = 1'b0;
    for (int i = 0; i < dbits; i++) begin
      f.bits[n] = d[i];
      p         = p ^ d[i];
      n++;
    end
    if (par != 0) begin
      f.bits[n] = (par == 1) ? ~p : p;
      n++;
    end
    f.nb = n + stops;
    return f;
  endfunction

  function automatic logic line(input int k);
    case (k)
      0:       return tx8;
      1:       return txe;
      default: return txo;
    endcase
  endfunction

  function automatic logic rdy(input int k);
    case (k)
      0:       return rdy8;
      1:       return rdye;
      default: return rdyo;
    endcase
  endfunction

  function automatic int div_of(input int k);
    return (k == 0) ? 5 : 4;
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop_exp(input int k, output frame_t f);
    case (k)
      0:       f = q0.pop_front();
      1:       f = q1.pop_front();
      default: f = q2.pop_front();
    endcase
  endtask

  // Presents one character for one clock; acc is the hand-derived acceptance (compared to tx_ready).
  task automatic load(input int k, input logic [8:0] d, input bit acc);
    chk($sformatf("ready_before_load_i%0d_%0h", k, d), rdy(k), acc);
    case (k)
      0: begin ld8 = 1'b1; d8  = d[7:0]; if (acc) q0.push_back(make_frame(d, 8, 0, 1)); end
      1: begin lde = 1'b1; de  = d[6:0]; if (acc) q1.push_back(make_frame(d, 7, 2, 2)); end
      default: begin ldo = 1'b1; dod = d[6:0]; if (acc) q2.push_back(make_frame(d, 7, 1, 2)); end
    endcase
    @(negedge clk);
    ld8 = 1'b0;
    lde = 1'b0;
    ldo = 1'b0;
  endtask

  // Monitor: on a start bit, pops the expected frame and checks every clock of every bit.
  task automatic mon(input int k);
    frame_t f;
    bit     ok, aborted, primed;
    logic   bad;
    primed = 1'b0;
    forever begin
      if (!primed) @(negedge clk);
      primed = 1'b0;
      if (nrst && line(k) == 1'b0) begin
        if (qsize(k) == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_start_i%0d: got tx=0, required idle 1 (t=%0t)", k, $time);
        end else begin
          pop_exp(k, f);
          aborted = 1'b0;
          for (int b = 0; b < f.nb && !aborted; b++) begin
            ok  = 1'b1;
            bad = 1'b0;
            for (int c = 0; c < div_of(k) && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (!nrst) aborted = 1'b1;
              else if (line(k) !== f.bits[b]) begin
                ok  = 1'b0;
                bad = line(k);
              end
            end
            if (!aborted) begin
              n_vec++;
              if (!ok) begin
                n_err++;
                $display("FAIL frame_bit_i%0d_b%0d: got %0b, required %0b (t=%0t)", k, b, bad, f.bits[b], $time);
              end
            end
          end
          if (!aborted && qsize(k) > 0) begin
            @(negedge clk);
            primed = 1'b1;
            if (nrst) chk($sformatf("no_gap_i%0d", k), line(k), 1'b0);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    step(3);
    chk("rst_tx", tx8, 1'b1);
    chk("rst_ready", rdy8, 1'b1);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_overrun", ovr8, 1'b0);
    chk("rst_tx_e", txe, 1'b1);
    nrst = 1'b1;
    step(3);

    // 8N1 0x55: start one clock after the buffered edge, busy for exactly 50 frame clocks
    load(0, 9'h055, 1'b1);
    chk("55_tx_after_load", tx8, 1'b1);
    chk("55_busy_after_load", busy8, 1'b1);
`ifdef UART_TX_FIFO_EN
    chk("55_ready_after_load", rdy8, 1'b1);
`else
    chk("55_ready_after_load", rdy8, 1'b0);
`endif
    step(1);
    chk("55_start_bit", tx8, 1'b0);
    chk("55_ready_after_pop", rdy8, 1'b1);
    step(49);
    chk("55_busy_last_clock", busy8, 1'b1);
    step(1);
    chk("55_busy_done", busy8, 1'b0);
    chk("55_tx_idle", tx8, 1'b1);
    step(3);

    // 7E2 and 7O2 of 0x41: parity 0 and 1 respectively, 44 clocks
    load(1, 9'h041, 1'b1);
    load(2, 9'h041, 1'b1);
    step(50);
    chk("7e2_busy_done", busye, 1'b0);
    chk("7o2_busy_done", busyo, 1'b0);

    // back-to-back
    load(0, 9'h0A5, 1'b1);
    step(10);
    load(0, 9'h03C, 1'b1);
    step(110);
    chk("b2b_busy_done", busy8, 1'b0);

`ifdef UART_TX_FIFO_EN
    chk("fifo_overrun_pre", ovr8, 1'b0);
    for (int i = 1; i <= 7; i++) load(0, 9'(i), (i <= 5));
    chk("fifo_overrun_set", ovr8, 1'b1);
    step(270);
    chk("fifo_busy_done", busy8, 1'b0);
`else
    chk("hold_overrun_pre", ovr8, 1'b0);
    load(0, 9'h011, 1'b1);
    step(3);
    load(0, 9'h022, 1'b1);
    step(3);
    load(0, 9'h033, 1'b0);
    chk("hold_overrun_set", ovr8, 1'b1);
    step(120);
    chk("hold_busy_done", busy8, 1'b0);
    chk("hold_overrun_sticky", ovr8, 1'b1);
`endif

    // reset during data bit 3 of an all-zero character
    load(0, 9'h000, 1'b1);
    step(22);
    chk("pre_reset_tx_low", tx8, 1'b0);
    #2 nrst = 1'b0;
    #1;
    chk("midreset_tx", tx8, 1'b1);
    chk("midreset_busy", busy8, 1'b0);
    chk("midreset_ready", rdy8, 1'b1);
    chk("midreset_overrun", ovr8, 1'b0);
    q0.delete();
    step(3);
    nrst = 1'b1;
    step(2);
    chk("post_reset_tx_idle", tx8, 1'b1);
    load(0, 9'h0FF, 1'b1);
    step(55);
    chk("ff_busy_done", busy8, 1'b0);

    step(10);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
